// File: rtl/afifo_rd_stream.sv
// -----------------------------------------------------------------------------
// afifo_rd_stream
//
// Read-side companion of the async FIFO. Reads words from the FIFO read port
// (fixed read latency RL), buffers the returned words in a small circular
// buffer, and presents them downstream as a valid/ready stream.
//
// Reads are only issued while the buffer has room for every word already
// requested, so backpressure never loses data. A steady 1 word/cycle flow is
// sustained while m_ready is held high.
//
// Parameters
//   DW           data width, equal to the FIFO data width
//   RL           FIFO read latency in cycles, from fifo_ren to fifo_rvld (1..4)
//
// Ports
//   rclk         read-domain clock
//   rrst         asynchronous active-low reset
//   rd_en        1 = allow new FIFO reads; 0 = stop issuing, keep draining
//   fifo_nempty  FIFO holds at least one readable word
//   fifo_ren     FIFO read enable
//   fifo_rdata   FIFO read data, qualified by fifo_rvld
//   fifo_rvld    FIFO read data valid, RL cycles after fifo_ren
//   m_valid      stream data valid
//   m_data       stream data
//   m_ready      stream ready from downstream
//   inflight     reads issued whose data has not yet returned
//   occ          words currently held in the return buffer
//   err_rvld     sticky flag: fifo_rvld seen while no read was outstanding
// -----------------------------------------------------------------------------
module afifo_rd_stream #(
  parameter int DW = 64,
  parameter int RL = 2
) (
  input  logic          rclk,
  input  logic          rrst,
  input  logic          rd_en,
  input  logic          fifo_nempty,
  output logic          fifo_ren,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          fifo_rvld,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic [2:0]    inflight,
  output logic [2:0]    occ,
  output logic          err_rvld
);

  // One buffer slot per read that can be outstanding during the read
  // latency, plus slack so the credit check never stalls a full-rate stream.
  localparam int DEPTH = RL + 2;
  localparam int PW    = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic       pop;
  logic       push;
  logic       unexp_rvld;
  logic [3:0] credit_used;
  logic [2:0] inflight_next;
  logic [2:0] occ_next;

  // Circular pointer increment, wrapping at DEPTH (not a power of two in
  // general).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake decode, read credit and next-state counters.
  // A word being popped this cycle frees its slot immediately, which is what
  // keeps fifo_ren continuously high at full throughput; this makes fifo_ren
  // combinational from m_ready. fifo_ren is also gated by the reset so that no
  // read can be issued while the block is held in reset.
  always_comb begin
    pop           = m_valid & m_ready;
    push          = fifo_rvld & (inflight != 3'd0);
    unexp_rvld    = fifo_rvld & (inflight == 3'd0);
    credit_used   = {1'b0, inflight} + {1'b0, occ} - {3'b000, pop};
    fifo_ren      = rrst & rd_en & fifo_nempty & (credit_used < 4'(DEPTH));
    inflight_next = inflight + {2'b00, fifo_ren} - {2'b00, push};
    occ_next      = occ + {2'b00, push} - {2'b00, pop};
  end

  // Return buffer storage, pointers, counters and the sticky error flag.
  // An unexpected rvld is dropped entirely: it neither writes the buffer nor
  // decrements inflight, so the counter cannot wrap below zero.
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      inflight <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err_rvld <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      inflight <= inflight_next;
      occ      <= occ_next;
      if (push) begin
        mem[wr_ptr] <= fifo_rdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (unexp_rvld) begin
        err_rvld <= 1'b1;
      end
    end
  end

  // The stream head is read straight out of registered storage; it only
  // changes on a pop or a push into an empty buffer, so m_data stays stable
  // while the downstream stalls.
  always_comb begin
    m_valid = (occ != 3'd0);
    m_data  = mem[rd_ptr];
  end

endmodule

// File: tb/tb_afifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_afifo_rd_stream
//
// Directed testbench for afifo_rd_stream. Three instances run side by side
// at RL=2 (index 0), RL=1 (index 1) and RL=4 (index 2), each fed by a small
// FIFO model: a word store with a read head plus an RL-stage return pipeline.
// An injection input forces a stray rvld for the error-flag test.
// -----------------------------------------------------------------------------
module tb_afifo_rd_stream;

  localparam int DW = 64;

  logic rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic          rrst;
  logic          rd_en   [3];
  logic          gate    [3];
  logic          m_ready [3];
  logic          inj     [3];
  logic [DW-1:0] inj_data;

  logic          nempty   [3];
  logic          ren      [3];
  logic          rvld     [3];
  logic          m_valid  [3];
  logic          err      [3];
  logic [DW-1:0] rdata    [3];
  logic [DW-1:0] m_data   [3];
  logic [2:0]    inflight [3];
  logic [2:0]    occ      [3];

  logic [DW-1:0] fmem [3][128];
  int            tail [3];

  logic [DW-1:0] olog   [3][128];
  int            ocnt   [3];
  int            rencnt [3];

  int checks = 0;
  int errors = 0;

  function automatic int rl_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  // FIFO model plus DUT for each read latency. The FIFO word store survives
  // rrst; only the return pipeline is cleared, like a real FIFO read port.
  for (genvar k = 0; k < 3; k++) begin : g_inst
    localparam int RLK = (k == 0) ? 2 : (k == 1) ? 1 : 4;

    int            head = 0;
    logic          pv [RLK];
    logic [DW-1:0] pd [RLK];

    assign nempty[k] = gate[k] && (head != tail[k]);
    assign rvld[k]   = inj[k] | pv[RLK-1];
    assign rdata[k]  = inj[k] ? inj_data : pd[RLK-1];

    always @(posedge rclk or negedge rrst) begin
      if (!rrst) begin
        for (int i = 0; i < RLK; i++) begin
          pv[i] <= 1'b0;
          pd[i] <= '0;
        end
      end else begin
        pv[0] <= ren[k];
        pd[0] <= fmem[k][head];
        if (ren[k]) head <= head + 1;
        for (int i = 1; i < RLK; i++) begin
          pv[i] <= pv[i-1];
          pd[i] <= pd[i-1];
        end
      end
    end

    afifo_rd_stream #(.DW(DW), .RL(RLK)) dut (
      .rclk        (rclk),
      .rrst        (rrst),
      .rd_en       (rd_en[k]),
      .fifo_nempty (nempty[k]),
      .fifo_ren    (ren[k]),
      .fifo_rdata  (rdata[k]),
      .fifo_rvld   (rvld[k]),
      .m_valid     (m_valid[k]),
      .m_data      (m_data[k]),
      .m_ready     (m_ready[k]),
      .inflight    (inflight[k]),
      .occ         (occ[k]),
      .err_rvld    (err[k])
    );
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input logic rd, input logic g, input logic mr);
    rd_en[k]   = rd;
    gate[k]    = g;
    m_ready[k] = mr;
  endtask

  task automatic loadWords(input int k, input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[k][tail[k]] = base + 64'(i);
      tail[k]++;
    end
  endtask

  // Logs words accepted downstream and issued reads, advances one clock,
  // then checks the buffer invariants on every instance.
  task automatic tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      if (m_valid[k] && m_ready[k] && ocnt[k] < 128) begin
        olog[k][ocnt[k]] = m_data[k];
        ocnt[k]++;
      end
      if (ren[k]) rencnt[k]++;
    end
    @(posedge rclk);
    #2;
    for (int k = 0; k < 3; k++) begin
      checkOutput("no_push_full",
                  64'(rvld[k] && inflight[k] != 3'd0 && occ[k] == 3'(rl_of(k) + 2)), 64'(0));
      checkOutput("occ_le_depth", 64'(int'(occ[k]) <= rl_of(k) + 2), 64'(1));
    end
  endtask

  initial begin
    int r;
    int d;
    int base;
    int rb;

    rrst     = 1'b0;
    inj_data = '0;
    for (int k = 0; k < 3; k++) begin
      rd_en[k]   = 1'b0;
      gate[k]    = 1'b0;
      m_ready[k] = 1'b0;
      inj[k]     = 1'b0;
      tail[k]    = 0;
      ocnt[k]    = 0;
      rencnt[k]  = 0;
    end

    // Reset values
    #3;
    for (int k = 0; k < 3; k++) begin
      checkOutput("rst_ren",      64'(ren[k]),      64'(0));
      checkOutput("rst_valid",    64'(m_valid[k]),  64'(0));
      checkOutput("rst_data",     m_data[k],        64'(0));
      checkOutput("rst_inflight", 64'(inflight[k]), 64'(0));
      checkOutput("rst_occ",      64'(occ[k]),      64'(0));
      checkOutput("rst_err",      64'(err[k]),      64'(0));
    end
    @(posedge rclk);
    #2;
    rrst = 1'b1;
    tick();
    tick();

    // Test 1: full-rate stream, 8 words, every read latency
    for (int k = 0; k < 3; k++) begin
      $display("[TB] test 1 full rate, RL=%0d", rl_of(k));
      r    = rl_of(k);
      base = ocnt[k];
      loadWords(k, 64'h10, 8);
      applyStimulus(k, 1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 8 + r + 4; c++) begin
        #1;
        checkOutput("t1_ren", 64'(ren[k]), 64'(c < 8));
        if (c >= r + 1 && c < r + 9) begin
          checkOutput("t1_valid", 64'(m_valid[k]), 64'(1));
          checkOutput("t1_data", m_data[k], 64'(32'h10 + c - r - 1));
        end else begin
          checkOutput("t1_valid", 64'(m_valid[k]), 64'(0));
        end
        tick();
      end
      applyStimulus(k, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_count",    64'(ocnt[k] - base), 64'(8));
      checkOutput("t1_inflight", 64'(inflight[k]),    64'(0));
      checkOutput("t1_occ",      64'(occ[k]),         64'(0));
    end

    // Test 2: downstream stalled from the start, then released
    for (int k = 0; k < 3; k++) begin
      $display("[TB] test 2 backpressure, RL=%0d", rl_of(k));
      r    = rl_of(k);
      d    = r + 2;
      base = ocnt[k];
      rb   = rencnt[k];
      loadWords(k, 64'h20, 8);
      applyStimulus(k, 1'b1, 1'b1, 1'b0);
      for (int c = 0; c < d + r + 3; c++) begin
        #1;
        checkOutput("t2_ren", 64'(ren[k]), 64'(c < d));
        tick();
      end
      #1;
      checkOutput("t2_occ",      64'(occ[k]),      64'(d));
      checkOutput("t2_inflight", 64'(inflight[k]), 64'(0));
      checkOutput("t2_valid",    64'(m_valid[k]),  64'(1));
      checkOutput("t2_head",     m_data[k],        64'h20);
      applyStimulus(k, 1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 20; c++) tick();
      applyStimulus(k, 1'b0, 1'b0, 1'b0);
      checkOutput("t2_count", 64'(ocnt[k] - base),   64'(8));
      checkOutput("t2_reads", 64'(rencnt[k] - rb),   64'(8));
      for (int i = 0; i < 8; i++) begin
        checkOutput("t2_order", olog[k][base + i], 64'h20 + 64'(i));
      end
    end

    // Test 3: m_ready toggling, 16 words, RL=2
    $display("[TB] test 3 toggling ready");
    base = ocnt[0];
    loadWords(0, 64'h30, 16);
    for (int c = 0; c < 48; c++) begin
      applyStimulus(0, 1'b1, 1'b1, (c % 2) == 0);
      tick();
    end
    applyStimulus(0, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_count", 64'(ocnt[0] - base), 64'(16));
    for (int i = 0; i < 16; i++) begin
      checkOutput("t3_order", olog[0][base + i], 64'h30 + 64'(i));
    end

    // Test 4: FIFO reports empty despite credit; single-cycle not-empty pulse
    $display("[TB] test 4 empty gating");
    r    = rl_of(0);
    base = ocnt[0];
    loadWords(0, 64'h40, 3);
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput("t4_noren", 64'(ren[0]), 64'(0));
      tick();
    end
    applyStimulus(0, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("t4_ren_pulse", 64'(ren[0]), 64'(1));
    tick();
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      #1;
      checkOutput("t4_ren_after", 64'(ren[0]), 64'(0));
      checkOutput("t4_valid", 64'(m_valid[0]), 64'(c == r + 1));
      if (c == r + 1) checkOutput("t4_data", m_data[0], 64'h40);
      tick();
    end
    checkOutput("t4_one_word", 64'(ocnt[0] - base), 64'(1));
    applyStimulus(0, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_count", 64'(ocnt[0] - base), 64'(3));
    checkOutput("t4_w1", olog[0][base + 1], 64'h41);
    checkOutput("t4_w2", olog[0][base + 2], 64'h42);

    // Test 5: stray rvld with nothing outstanding
    $display("[TB] test 5 unexpected rvld");
    #1;
    checkOutput("t5_err_pre", 64'(err[0]), 64'(0));
    inj_data = 64'hDEAD;
    inj[0]   = 1'b1;
    tick();
    inj[0] = 1'b0;
    #1;
    checkOutput("t5_err",      64'(err[0]),      64'(1));
    checkOutput("t5_occ",      64'(occ[0]),      64'(0));
    checkOutput("t5_valid",    64'(m_valid[0]),  64'(0));
    checkOutput("t5_inflight", 64'(inflight[0]), 64'(0));
    for (int c = 0; c < 3; c++) tick();
    #1;
    checkOutput("t5_err_sticky", 64'(err[0]), 64'(1));

    // Test 6: asynchronous reset with words in flight and buffered, RL=4
    $display("[TB] test 6 reset mid-stream");
    base = ocnt[2];
    loadWords(2, 64'h50, 8);
    applyStimulus(2, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    applyStimulus(2, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    #1;
    checkOutput("t6_setup_inflight", 64'(inflight[2]), 64'(2));
    checkOutput("t6_setup_occ",      64'(occ[2]),      64'(3));
    applyStimulus(2, 1'b1, 1'b1, 1'b1);
    #1;
    rrst = 1'b0;
    #1;
    checkOutput("t6_ren",      64'(ren[2]),      64'(0));
    checkOutput("t6_valid",    64'(m_valid[2]),  64'(0));
    checkOutput("t6_data",     m_data[2],        64'(0));
    checkOutput("t6_inflight", 64'(inflight[2]), 64'(0));
    checkOutput("t6_occ",      64'(occ[2]),      64'(0));
    checkOutput("t6_err_clr",  64'(err[0]),      64'(0));
    @(posedge rclk);
    #2;
    rrst = 1'b1;
    for (int c = 0; c < 15; c++) tick();
    applyStimulus(2, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_count", 64'(ocnt[2] - base), 64'(3));
    checkOutput("t6_w0", olog[2][base],     64'h55);
    checkOutput("t6_w1", olog[2][base + 1], 64'h56);
    checkOutput("t6_w2", olog[2][base + 2], 64'h57);
    checkOutput("t6_err", 64'(err[2]), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
